// File: rtl/pmux_ctrl.sv
// Project mux controller: synchronised pad address/enable, break-before-make slot select, registered slot outputs.
// Build option PMUX_ADDR_READBACK_EN: uo_out shows {1'b1, zero-pad, cur_addr} while no slot is active.
module pmux_ctrl #(
    parameter int NUM_PROJ  = 8,
    parameter int ADDR_W    = 3,
    parameter int GUARD_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_sel_rst_n,
    input  logic                    ctrl_sel_inc,
    input  logic                    ctrl_ena,
    input  logic [7:0]              ui_in,
    input  logic [7:0]              uio_in,
    input  logic                    user_clk,
    input  logic                    user_rst_n,
    output logic [17:0]             iw,
    output logic [NUM_PROJ-1:0]     ena,
    input  logic [NUM_PROJ*24-1:0]  ow,
    output logic [7:0]              uo_out,
    output logic [7:0]              uio_out,
    output logic [7:0]              uio_oe,
    output logic [ADDR_W-1:0]       cur_addr
);
    localparam int GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYC);
    localparam logic [ADDR_W:0] PROJ_LIM = (ADDR_W+1)'(NUM_PROJ);

    typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       gcnt, gcnt_nxt;
    logic [1:0]          srst_sync, inc_sync, en_sync;
    logic                inc_prev;
    logic                sel_rst_n_s, en_s, inc_rise;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                addr_ok;
    logic [23:0]         slot_sel;
    logic [NUM_PROJ-1:0] ena_nxt;
    logic [7:0]          idle_uo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srst_sync <= 2'b11;
            inc_sync  <= 2'b00;
            en_sync   <= 2'b00;
            inc_prev  <= 1'b0;
        end else begin
            srst_sync <= {srst_sync[0], ctrl_sel_rst_n};
            inc_sync  <= {inc_sync[0], ctrl_sel_inc};
            en_sync   <= {en_sync[0], ctrl_ena};
            inc_prev  <= inc_sync[1];
        end
    end

    assign sel_rst_n_s = srst_sync[1];
    assign en_s        = en_sync[1];
    assign inc_rise    = inc_sync[1] & ~inc_prev;

    // Decisions look at the address the counter is about to hold, so a
    // select never starts on a slot that is being stepped away from.
    always_comb begin
        addr_nxt = cur_addr;
        if (!sel_rst_n_s) begin
            addr_nxt = '0;
        end else if (inc_rise) begin
            addr_nxt = cur_addr + ADDR_W'(1);
        end
    end

    assign addr_ok = ({1'b0, addr_nxt} < PROJ_LIM);

    always_comb begin
        state_nxt = state;
        gcnt_nxt  = gcnt;
        case (state)
            IDLE: begin
                if (en_s && sel_rst_n_s && addr_ok) begin
                    state_nxt = GUARD;
                    gcnt_nxt  = GUARD_LD;
                end
            end
            GUARD, ACTIVE: begin
                if (!en_s || !sel_rst_n_s || !addr_ok) begin
                    state_nxt = IDLE;
                    gcnt_nxt  = '0;
                end else if (inc_rise) begin
                    state_nxt = GUARD;
                    gcnt_nxt  = GUARD_LD;
                end else if (state == GUARD) begin
                    if (gcnt == '0) begin
                        state_nxt = ACTIVE;
                    end else begin
                        gcnt_nxt = gcnt - GW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        slot_sel = '0;
        ena_nxt  = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (addr_nxt == ADDR_W'(k)) begin
                slot_sel   = ow[k*24 +: 24];
                ena_nxt[k] = (state_nxt == ACTIVE);
            end
        end
    end

`ifdef PMUX_ADDR_READBACK_EN
    assign idle_uo = 8'h80 | 8'(addr_nxt);
`else
    assign idle_uo = 8'h00;
`endif

    // Outputs are registered from the next state so they stay aligned with ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gcnt     <= '0;
            cur_addr <= '0;
            ena      <= '0;
            uo_out   <= 8'h00;
            uio_out  <= 8'h00;
            uio_oe   <= 8'h00;
        end else begin
            state    <= state_nxt;
            gcnt     <= gcnt_nxt;
            cur_addr <= addr_nxt;
            ena      <= ena_nxt;
            if (state_nxt == ACTIVE) begin
                {uio_oe, uio_out, uo_out} <= slot_sel;
            end else begin
                uo_out  <= idle_uo;
                uio_out <= 8'h00;
                uio_oe  <= 8'h00;
            end
        end
    end

    assign iw = {uio_in, ui_in, user_rst_n & (state == ACTIVE), user_clk};

endmodule
